detector_scheduler: RTL and testbench

//   Time-multiplexes one shared single-input pulse detector (in/smOut FSM) across NCH

---
 rtl/detector_scheduler.sv | 121 ++++++++++++
 tb/tb_detector_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_scheduler.sv
// detector_scheduler
//   Time-multiplexes one shared single-input pulse detector across NCH input lines.
//   A scan visits channels 0..NCH-1 in order: reset the detector for one cycle, route
//   the channel's line to it for DWELL cycles, then step to the next channel. Each
//   DWELL cycle where the detector fires sets that channel's hit bit and bumps a
//   saturating total hit counter.
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst      synchronous active-low reset
//   i_start    begin a scan (sampled only in IDLE)
//   i_stop     abort a scan; wins over i_start in IDLE
//   i_ch_in    NCH input lines being scanned
//   i_sm_out   output of the shared detector
//   o_sm_in    detector input: i_ch_in[o_sel] while dwelling, else 0
//   o_sm_rst   detector reset (active-high), high only in CLEAR
//   o_sel      channel currently scanned
//   o_busy     high in CLEAR/DWELL/NEXT
//   o_done     one-cycle pulse at scan completion
//   o_hit_vec  per-channel "detector fired" flags for this scan
//   o_hit_cnt  total DWELL cycles with detector firing, saturating
module detector_scheduler #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DWELL = 8,
  parameter int unsigned CW    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [NCH-1:0]          i_ch_in,
  input  logic                    i_sm_out,
  output logic                    o_sm_in,
  output logic                    o_sm_rst,
  output logic [$clog2(NCH)-1:0]  o_sel,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [NCH-1:0]          o_hit_vec,
  output logic [CW-1:0]           o_hit_cnt
);

  localparam int unsigned SW = $clog2(NCH);
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW-1:0] LastSel   = SW'(NCH - 1);
  localparam logic [DW-1:0] LastDwell = DW'(DWELL - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StDwell = 3'd2,
    StNext  = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [SW-1:0]   r_sel;
  logic [DW-1:0]   r_dwell_cnt;
  logic [NCH-1:0]  r_hit_vec;
  logic [CW-1:0]   r_hit_cnt;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (i_start && !i_stop) w_state_d = StClear;
      StClear: w_state_d = StDwell;
      StDwell: if (r_dwell_cnt == LastDwell) w_state_d = StNext;
      StNext:  w_state_d = (r_sel == LastSel) ? StDone : StClear;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // Abort from any active state; IDLE already handles stop above.
    if (r_state != StIdle && i_stop) w_state_d = StIdle;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_sel       <= '0;
      r_dwell_cnt <= '0;
      r_hit_vec   <= '0;
      r_hit_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StIdle: begin
          if (w_state_d == StClear) begin
            r_sel     <= '0;
            r_hit_vec <= '0;
            r_hit_cnt <= '0;
          end
        end
        StClear: r_dwell_cnt <= '0;
        StDwell: begin
          r_dwell_cnt <= r_dwell_cnt + DW'(1);
          if (i_sm_out) begin
            r_hit_vec[r_sel] <= 1'b1;
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CW'(1);
          end
        end
        StNext: begin
          // sel only advances when moving on to another channel; abort keeps it.
          if (w_state_d == StClear) r_sel <= r_sel + SW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_sm_rst = (r_state == StClear);
    o_busy   = (r_state == StClear) || (r_state == StDwell) || (r_state == StNext);
    o_done   = (r_state == StDone);
    o_sm_in  = (r_state == StDwell) ? i_ch_in[r_sel] : 1'b0;
  end

  assign o_sel     = r_sel;
  assign o_hit_vec = r_hit_vec;
  assign o_hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_detector_scheduler.sv
// Bench for detector_scheduler: a rising-edge pulse detector model stands in for
// the shared detector; a second instance with CW=2 and the detector output tied
// high exercises counter saturation. Expected scan results go into a scoreboard
// queue when a scan is launched and are popped when done is seen.
module tb_detector_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] ch_in = 4'b0000;

  logic       sm_in, sm_rst, busy, done;
  logic [1:0] sel;
  logic [3:0] hit_vec;
  logic [7:0] hit_cnt;
  logic       sm_out = 1'b0;
  logic       det_prev = 1'b0;

  logic       s_sm_in, s_sm_rst, s_busy, s_done;
  logic [1:0] s_sel;
  logic [3:0] s_hit_vec;
  logic [1:0] s_hit_cnt;
  logic       s_sm_out = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] vec;
    logic [7:0] cnt;
    int         lat;
  } exp_t;
  exp_t sb[$];

  detector_scheduler #(.NCH(4), .DWELL(8), .CW(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_ch_in(ch_in),
    .i_sm_out(sm_out), .o_sm_in(sm_in), .o_sm_rst(sm_rst), .o_sel(sel), .o_busy(busy),
    .o_done(done), .o_hit_vec(hit_vec), .o_hit_cnt(hit_cnt)
  );

  detector_scheduler #(.NCH(4), .DWELL(8), .CW(2)) u_dut_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_ch_in(ch_in),
    .i_sm_out(s_sm_out), .o_sm_in(s_sm_in), .o_sm_rst(s_sm_rst), .o_sel(s_sel),
    .o_busy(s_busy), .o_done(s_done), .o_hit_vec(s_hit_vec), .o_hit_cnt(s_hit_cnt)
  );

  always #5 clk = ~clk;

  // Detector model: fires for one cycle after a 0->1 transition on its input.
  always @(posedge clk) begin
    if (sm_rst) begin
      det_prev <= 1'b0;
      sm_out   <= 1'b0;
    end else begin
      det_prev <= sm_in;
      sm_out   <= sm_in & ~det_prev;
    end
  end

  // Launches a scan and follows it cycle by cycle. Cycle 1 is the first cycle after
  // the edge that samples start. Per channel: CLEAR, 8 DWELL, NEXT (10 cycles).
  task automatic run_scan(input logic [3:0] chv, input int restart_at,
                          output int lat, output int rst_pulses, output int proto_bad);
    int   ph;
    int   chn;
    logic exp_in;
    lat = -1;
    rst_pulses = 0;
    proto_bad = 0;
    @(negedge clk);
    ch_in = chv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (sm_rst) rst_pulses++;
      if (c <= 40) begin
        ph = (c - 1) % 10;
        chn = (c - 1) / 10;
        exp_in = (ph >= 1 && ph <= 8) ? chv[chn] : 1'b0;
        if (sm_rst !== (ph == 0) || busy !== 1'b1 || sel !== chn[1:0] || sm_in !== exp_in)
          proto_bad++;
      end
      start = (c == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sm_rst, sm_in, sel, hit_vec, hit_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_initial: got busy=%b done=%b sm_rst=%b sel=%0d vec=%b cnt=%0d want all 0",
               busy, done, sm_rst, sel, hit_vec, hit_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    ch_in = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (hit_vec !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_hit: got vec=%b busy=%b want vec=0001 busy=1", hit_vec, busy);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sm_rst, sm_in, sel, hit_vec, hit_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_dwell: got busy=%b done=%b sm_rst=%b sel=%0d vec=%b cnt=%0d want all 0",
               busy, done, sm_rst, sel, hit_vec, hit_cnt);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sm_rst !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b sm_rst=%b want 0 0", busy, sm_rst);
    end
  endtask

  task automatic test_full_scan();
    int   lat, rp, pb;
    exp_t e;
    sb.push_back('{vec: 4'b0100, cnt: 8'd1, lat: 41});
    run_scan(4'b0100, 0, lat, rp, pb);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL full_latency: got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (hit_vec !== e.vec || hit_cnt !== e.cnt) begin
      errors++;
      $display("FAIL full_hits: got vec=%b cnt=%0d want vec=%b cnt=%0d", hit_vec, hit_cnt, e.vec, e.cnt);
    end
    checks++;
    if (rp !== 4) begin
      errors++;
      $display("FAIL full_sm_rst_pulses: got %0d want 4", rp);
    end
    checks++;
    if (pb !== 0) begin
      errors++;
      $display("FAIL full_per_cycle_outputs: got %0d bad cycles want 0", pb);
    end
    checks++;
    if (busy !== 1'b0 || sel !== 2'd3) begin
      errors++;
      $display("FAIL full_done_state: got busy=%b sel=%0d want busy=0 sel=3", busy, sel);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || hit_vec !== e.vec || hit_cnt !== e.cnt) begin
      errors++;
      $display("FAIL full_after_done: got done=%b vec=%b cnt=%0d want done=0 vec=%b cnt=%0d",
               done, hit_vec, hit_cnt, e.vec, e.cnt);
    end
  endtask

  task automatic test_idle_lines();
    int   lat, rp, pb;
    exp_t e;
    sb.push_back('{vec: 4'b0000, cnt: 8'd0, lat: 41});
    run_scan(4'b0000, 0, lat, rp, pb);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || hit_vec !== e.vec || hit_cnt !== e.cnt || pb !== 0) begin
      errors++;
      $display("FAIL idle_scan: got lat=%0d vec=%b cnt=%0d bad=%0d want lat=%0d vec=%b cnt=%0d bad=0",
               lat, hit_vec, hit_cnt, pb, e.lat, e.vec, e.cnt);
    end
  endtask

  task automatic test_saturation();
    int   lat, rp, pb;
    exp_t e;
    sb.push_back('{vec: 4'b1111, cnt: 8'd3, lat: 41});
    run_scan(4'b1111, 0, lat, rp, pb);
    e = sb.pop_front();
    checks++;
    if (s_done !== 1'b1 || lat !== e.lat) begin
      errors++;
      $display("FAIL sat_done: got s_done=%b lat=%0d want 1 %0d", s_done, lat, e.lat);
    end
    checks++;
    if (s_hit_cnt !== e.cnt[1:0] || s_hit_vec !== e.vec) begin
      errors++;
      $display("FAIL sat_hits: got vec=%b cnt=%0d want vec=%b cnt=%0d", s_hit_vec, s_hit_cnt, e.vec, e.cnt);
    end
    checks++;
    if (hit_vec !== 4'b1111 || hit_cnt !== 8'd4) begin
      errors++;
      $display("FAIL all_lines_hits: got vec=%b cnt=%0d want vec=1111 cnt=4", hit_vec, hit_cnt);
    end
  endtask

  task automatic test_abort();
    int   lat, rp, pb;
    int   late_done;
    exp_t e;
    @(negedge clk);
    ch_in = 4'b0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sel !== 2'd1) begin
      errors++;
      $display("FAIL abort_pre: got busy=%b sel=%0d want 1 1", busy, sel);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sel !== 2'd1 || sm_in !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b done=%b sel=%0d sm_in=%b want 0 0 1 0", busy, done, sel, sm_in);
    end
    checks++;
    if (hit_vec !== 4'b0010 || hit_cnt !== 8'd1) begin
      errors++;
      $display("FAIL abort_partial: got vec=%b cnt=%0d want vec=0010 cnt=1", hit_vec, hit_cnt);
    end
    late_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    checks++;
    if (late_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles want 0", late_done);
    end
    sb.push_back('{vec: 4'b0100, cnt: 8'd1, lat: 41});
    run_scan(4'b0100, 0, lat, rp, pb);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || hit_vec !== e.vec || hit_cnt !== e.cnt || pb !== 0) begin
      errors++;
      $display("FAIL abort_restart: got lat=%0d vec=%b cnt=%0d bad=%0d want lat=%0d vec=%b cnt=%0d bad=0",
               lat, hit_vec, hit_cnt, pb, e.lat, e.vec, e.cnt);
    end
  endtask

  task automatic test_priority();
    int   lat, rp, pb;
    int   active;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    active = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || sm_rst) active++;
    end
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (active !== 0) begin
      errors++;
      $display("FAIL start_stop_idle: got %0d active cycles want 0", active);
    end
    sb.push_back('{vec: 4'b1000, cnt: 8'd1, lat: 41});
    run_scan(4'b1000, 20, lat, rp, pb);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || hit_vec !== e.vec || hit_cnt !== e.cnt || pb !== 0) begin
      errors++;
      $display("FAIL start_while_busy: got lat=%0d vec=%b cnt=%0d bad=%0d want lat=%0d vec=%b cnt=%0d bad=0",
               lat, hit_vec, hit_cnt, pb, e.lat, e.vec, e.cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_scan();
    test_idle_lines();
    test_saturation();
    test_abort();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
